mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum cycles in ISSUE awaiting i_mem_ack (range 2..255).
REQ-003 SHALL have port i_clk, input, 1, the rising-edge clock.
REQ-004 SHALL have port i_rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port i_if_req, input, 1, fetch request, held until o_if_ack.
REQ-006 SHALL have port i_if_addr, input, XLEN, fetch address (word read).
REQ-007 SHALL have port o_if_ack, output, 1, one-cycle fetch completion pulse.
REQ-008 SHALL have port o_if_data, output, XLEN, fetch read data, valid with o_if_ack.
REQ-009 SHALL have port i_ls_req, input, 1, load/store request, held until o_ls_ack.
REQ-010 SHALL have ports i_ls_addr (input, XLEN), i_ls_data (input, XLEN, store data), i_ls_funct3 (input, 3, access type) and i_ls_rw (input, 1, 0=read, 1=write).
REQ-011 SHALL have port o_ls_ack, output, 1, one-cycle load/store completion pulse.
REQ-012 SHALL have port o_ls_data, output, XLEN, load data, valid with o_ls_ack.
REQ-013 SHALL have port o_err, output, 1, timeout pulse coincident with the failing requester's ack.
REQ-014 SHALL have memory-side outputs o_mem_req (1), o_mem_addr (XLEN), o_mem_data (XLEN), o_mem_funct3 (3) and o_mem_rw (1).
REQ-015 SHALL have memory-side inputs i_mem_ack (1) and i_mem_data (XLEN); the memory may acknowledge combinationally in the same cycle as o_mem_req.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-017 In IDLE with at least one request, SHALL grant per arbitration policy, register that requester's command, record the owner, and go to ISSUE the next cycle.
REQ-018 SHALL drive the fetch command as funct3=3'b010 and rw=0, ignoring the fetch port's store fields.
REQ-019 In ISSUE, SHALL hold o_mem_req=1 with the registered command stable; requester-side input changes SHALL NOT alter it.
REQ-020 In ISSUE with i_mem_ack=1, SHALL capture i_mem_data into the owner's data register and go to RESP.
REQ-021 In RESP, SHALL pulse only the owner's ack for exactly one cycle with o_mem_req=0, then return to IDLE.
REQ-022 Minimum transaction latency, grant cycle to ack cycle, SHALL be 2 cycles; back-to-back grants SHALL be separated by at least 1 IDLE cycle.
REQ-023 SHALL count ISSUE cycles with an 8-bit counter; if the count reaches TIMEOUT without i_mem_ack, it SHALL go to RESP, pulse ack with o_err=1 and data 0.
REQ-024 SHALL clear the timeout counter on every entry to ISSUE.
REQ-025 A request dropped before its ack SHALL still complete; the ack SHALL be issued and ignored.
REQ-026 o_if_data and o_ls_data SHALL hold their last captured value between acks.
REQ-027 With no request pending, o_mem_addr, o_mem_data, o_mem_funct3 and o_mem_rw SHALL hold their last value.

Reset
REQ-028 When i_rst_n=0 at a rising edge, SHALL set: FSM to IDLE; o_mem_req, o_if_ack, o_ls_ack and o_err to 0; all data/command registers to 0; timeout counter to 0; last-owner to fetch.
REQ-029 Reset asserted during ISSUE or RESP SHALL abandon the transaction and produce no ack after release.

Configuration
REQ-030 SHALL support macro MEM_ARB_ROUND_ROBIN_EN.
REQ-031 With MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests SHALL grant the requester not granted last; a lone request SHALL always be granted.
REQ-032 Without MEM_ARB_ROUND_ROBIN_EN, the load/store port SHALL have fixed priority over fetch, and the last-owner register SHALL be omitted.

Verification
REQ-033 Fetch only, addr=0x10, memory acks same cycle with 0xDEADBEEF -> o_mem_req high 1 cycle; o_if_ack pulse 2 cycles after grant; o_if_data=0xDEADBEEF.
REQ-034 Store, funct3=000, addr=0x21, data=0xAB -> o_mem_rw=1, o_mem_funct3=000, o_mem_addr=0x21 stable throughout ISSUE; single o_ls_ack.
REQ-035 Both requesting continuously, round-robin on -> grants alternate LS, IF, LS, IF; round-robin off -> LS granted on every grant.
REQ-036 Memory never acks, TIMEOUT=16 -> 16 ISSUE cycles, then owner ack with o_err=1 and data 0; FSM returns to IDLE.
REQ-037 i_rst_n=0 asserted in ISSUE -> next cycle o_mem_req=0; no ack after release; a fresh request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle for mem_arbiter: one fetch port, one load/store port, one memory port.
// The slave modport is the arbiter's view; the master modport is the view of whatever surrounds it.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_ack;
  logic [XLEN-1:0] o_if_data;

  logic            i_ls_req;
  logic [XLEN-1:0] i_ls_addr;
  logic [XLEN-1:0] i_ls_data;
  logic [2:0]      i_ls_funct3;
  logic            i_ls_rw;
  logic            o_ls_ack;
  logic [XLEN-1:0] o_ls_data;

  logic            o_err;

  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_data;
  logic [2:0]      o_mem_funct3;
  logic            o_mem_rw;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_data;

  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_addr, i_ls_data, i_ls_funct3, i_ls_rw,
    input  i_mem_ack, i_mem_data,
    output o_if_ack, o_if_data, o_ls_ack, o_ls_data, o_err,
    output o_mem_req, o_mem_addr, o_mem_data, o_mem_funct3, o_mem_rw
  );

  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_addr, i_ls_data, i_ls_funct3, i_ls_rw,
    output i_mem_ack, i_mem_data,
    input  o_if_ack, o_if_data, o_ls_ack, o_ls_data, o_err,
    input  o_mem_req, o_mem_addr, o_mem_data, o_mem_funct3, o_mem_rw
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single memory port, IDLE/ISSUE/RESP with an ISSUE timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is load/store fixed priority.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  state_e          state_r, state_next_s;
  logic            owner_ls_r, owner_ls_next_s;
  logic [7:0]      tmo_cnt_r, tmo_cnt_next_s;
  logic            mem_req_r, mem_req_next_s;
  logic [XLEN-1:0] mem_addr_r, mem_addr_next_s;
  logic [XLEN-1:0] mem_data_r, mem_data_next_s;
  logic [2:0]      mem_funct3_r, mem_funct3_next_s;
  logic            mem_rw_r, mem_rw_next_s;
  logic            if_ack_r, if_ack_next_s;
  logic            ls_ack_r, ls_ack_next_s;
  logic            err_r, err_next_s;
  logic [XLEN-1:0] if_data_r, if_data_next_s;
  logic [XLEN-1:0] ls_data_r, ls_data_next_s;
  logic            grant_ls_s;

  // Arbitration; owner_ls_r doubles as the last-granted record for round-robin.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.i_if_req && bus.i_ls_req) begin
      grant_ls_s = !owner_ls_r;
    end else begin
      grant_ls_s = bus.i_ls_req;
    end
`else
    grant_ls_s = bus.i_ls_req;
`endif
  end

  // Next-state and next register values for the transaction FSM.
  always_comb begin
    state_next_s      = state_r;
    owner_ls_next_s   = owner_ls_r;
    tmo_cnt_next_s    = tmo_cnt_r;
    mem_req_next_s    = mem_req_r;
    mem_addr_next_s   = mem_addr_r;
    mem_data_next_s   = mem_data_r;
    mem_funct3_next_s = mem_funct3_r;
    mem_rw_next_s     = mem_rw_r;
    if_data_next_s    = if_data_r;
    ls_data_next_s    = ls_data_r;
    if_ack_next_s     = 1'b0;
    ls_ack_next_s     = 1'b0;
    err_next_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_if_req || bus.i_ls_req) begin
          state_next_s    = ISSUE;
          mem_req_next_s  = 1'b1;
          tmo_cnt_next_s  = 8'd0;
          owner_ls_next_s = grant_ls_s;
          if (grant_ls_s) begin
            mem_addr_next_s   = bus.i_ls_addr;
            mem_data_next_s   = bus.i_ls_data;
            mem_funct3_next_s = bus.i_ls_funct3;
            mem_rw_next_s     = bus.i_ls_rw;
          end else begin
            mem_addr_next_s   = bus.i_if_addr;
            mem_funct3_next_s = FETCH_FUNCT3;
            mem_rw_next_s     = 1'b0;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.i_mem_ack || (tmo_cnt_r == TIMEOUT_LAST)) begin
          // A real ack on the last allowed cycle wins over the timeout.
          state_next_s   = RESP;
          mem_req_next_s = 1'b0;
          err_next_s     = !bus.i_mem_ack;
          if (owner_ls_r) begin
            ls_ack_next_s  = 1'b1;
            ls_data_next_s = bus.i_mem_ack ? bus.i_mem_data : {XLEN{1'b0}};
          end else begin
            if_ack_next_s  = 1'b1;
            if_data_next_s = bus.i_mem_ack ? bus.i_mem_data : {XLEN{1'b0}};
          end
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + 8'd1;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s   = IDLE;
        mem_req_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      owner_ls_r   <= 1'b0;
      tmo_cnt_r    <= 8'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {XLEN{1'b0}};
      mem_data_r   <= {XLEN{1'b0}};
      mem_funct3_r <= 3'b000;
      mem_rw_r     <= 1'b0;
      if_ack_r     <= 1'b0;
      ls_ack_r     <= 1'b0;
      err_r        <= 1'b0;
      if_data_r    <= {XLEN{1'b0}};
      ls_data_r    <= {XLEN{1'b0}};
    end else begin
      state_r      <= state_next_s;
      owner_ls_r   <= owner_ls_next_s;
      tmo_cnt_r    <= tmo_cnt_next_s;
      mem_req_r    <= mem_req_next_s;
      mem_addr_r   <= mem_addr_next_s;
      mem_data_r   <= mem_data_next_s;
      mem_funct3_r <= mem_funct3_next_s;
      mem_rw_r     <= mem_rw_next_s;
      if_ack_r     <= if_ack_next_s;
      ls_ack_r     <= ls_ack_next_s;
      err_r        <= err_next_s;
      if_data_r    <= if_data_next_s;
      ls_data_r    <= ls_data_next_s;
    end
  end

  assign bus.o_mem_req    = mem_req_r;
  assign bus.o_mem_addr   = mem_addr_r;
  assign bus.o_mem_data   = mem_data_r;
  assign bus.o_mem_funct3 = mem_funct3_r;
  assign bus.o_mem_rw     = mem_rw_r;
  assign bus.o_if_ack     = if_ack_r;
  assign bus.o_ls_ack     = ls_ack_r;
  assign bus.o_err        = err_r;
  assign bus.o_if_data    = if_data_r;
  assign bus.o_ls_data    = ls_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus arbitration, reset-abort and dropped-request sequences.
module tb_mem_arbiter;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();
  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
  } sb_t;

  typedef struct {
    logic        is_ls;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        rw;
    int          mem_lat;
    logic [31:0] rdata;
    logic [2:0]  exp_funct3;
    logic        exp_rw;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_req_cyc;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_cnt  = 0;
  int          mem_lat  = 200;
  int          issue_cyc = 0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] exp_if_hold = 32'h0;
  logic [31:0] exp_ls_hold = 32'h0;
  sb_t         sb_q[$];
  vec_t        vecs[9];

  // Memory model: acknowledges combinationally once it has seen mem_lat earlier ISSUE cycles.
  always @(posedge clk) issue_cyc <= bus.o_mem_req ? issue_cyc + 1 : 0;
  assign bus.i_mem_ack  = bus.o_mem_req && (issue_cyc == mem_lat);
  assign bus.i_mem_data = mem_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every ack pops the oldest expected completion.
  initial begin
    sb_t e;
    logic [31:0] got_data;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.o_if_ack || bus.o_ls_ack)) begin
        ack_cnt++;
        check("sb_has_entry", sb_q.size() > 0, 1'b1);
        check("ack_exclusive", bus.o_if_ack & bus.o_ls_ack, 1'b0);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          got_data = e.is_ls ? bus.o_ls_data : bus.o_if_data;
          check("ack_port", bus.o_ls_ack, e.is_ls);
          check("ack_data", got_data, e.data);
          check("ack_err", bus.o_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_if_hold = 32'h0;
    exp_ls_hold = 32'h0;
  endtask

  task automatic do_txn(input vec_t v, input bit drop_early);
    sb_t e;
    int  lat;
    int  req_cyc;
    bit  got;
    bit  stable;
    lat = 0; req_cyc = 0; got = 1'b0; stable = 1'b1;
    @(posedge clk); #1;
    mem_lat   = v.mem_lat;
    mem_rdata = v.rdata;
    e.is_ls = v.is_ls; e.data = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    if (v.is_ls) begin
      bus.i_ls_addr = v.addr; bus.i_ls_data = v.wdata;
      bus.i_ls_funct3 = v.funct3; bus.i_ls_rw = v.rw;
      bus.i_ls_req = 1'b1;
    end else begin
      bus.i_if_addr = v.addr;
      bus.i_if_req  = 1'b1;
    end
    @(posedge clk); #1;
    // Disturb requester fields after the grant; the issued command must not follow them.
    bus.i_if_addr = ~v.addr; bus.i_ls_addr = ~v.addr; bus.i_ls_data = ~v.wdata;
    bus.i_ls_funct3 = ~v.funct3; bus.i_ls_rw = ~v.rw;
    if (drop_early) begin
      bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
    end
    for (int k = 1; k <= 64 && !got; k++) begin
      @(negedge clk);
      if (bus.o_mem_req) begin
        req_cyc++;
        if (bus.o_mem_addr !== v.addr || bus.o_mem_funct3 !== v.exp_funct3 ||
            bus.o_mem_rw !== v.exp_rw || (v.is_ls && bus.o_mem_data !== v.wdata)) stable = 1'b0;
      end
      if (bus.o_if_ack || bus.o_ls_ack) begin
        got = 1'b1;
        lat = k;
        check("ack_mem_req_low", bus.o_mem_req, 1'b0);
      end
    end
    check("ack_seen", got, 1'b1);
    check("latency", lat, v.exp_lat);
    check("issue_cycles", req_cyc, v.exp_req_cyc);
    check("cmd_stable", stable, 1'b1);
    @(posedge clk); #1;
    bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {bus.o_if_ack, bus.o_ls_ack, bus.o_err}, 3'b000);
    check("mem_req_idle", bus.o_mem_req, 1'b0);
    check("mem_addr_hold", bus.o_mem_addr, v.addr);
    if (v.is_ls) exp_ls_hold = v.exp_rdata;
    else exp_if_hold = v.exp_rdata;
    check("if_data_hold", bus.o_if_data, exp_if_hold);
    check("ls_data_hold", bus.o_ls_data, exp_ls_hold);
  endtask

  initial begin
    logic arb_ord[4];
    sb_t  e;
    vec_t v;
    int   n;
    int   cyc;
    int   prev;
    int   acks_before;
    int   req_hi;

    // is_ls addr wdata f3 rw lat rdata | exp_f3 exp_rw exp_data err lat req_cyc
    vecs[0] = '{1'b0, 32'h10,  32'h0,    3'b000, 1'b0, 0,   32'hDEADBEEF, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0, 2,  1};
    vecs[1] = '{1'b1, 32'h21,  32'hAB,   3'b000, 1'b1, 0,   32'h00000055, 3'b000, 1'b1, 32'h00000055, 1'b0, 2,  1};
    vecs[2] = '{1'b1, 32'h100, 32'h0,    3'b010, 1'b0, 3,   32'h12345678, 3'b010, 1'b0, 32'h12345678, 1'b0, 5,  4};
    vecs[3] = '{1'b0, 32'h200, 32'h0,    3'b000, 1'b0, 1,   32'hCAFEF00D, 3'b010, 1'b0, 32'hCAFEF00D, 1'b0, 3,  2};
    vecs[4] = '{1'b1, 32'h104, 32'h0,    3'b100, 1'b0, 14,  32'h0BADF00D, 3'b100, 1'b0, 32'h0BADF00D, 1'b0, 16, 15};
    vecs[5] = '{1'b0, 32'h204, 32'h0,    3'b000, 1'b0, 15,  32'h13579BDF, 3'b010, 1'b0, 32'h13579BDF, 1'b0, 17, 16};
    vecs[6] = '{1'b0, 32'h208, 32'h0,    3'b000, 1'b0, 200, 32'hFFFF0000, 3'b010, 1'b0, 32'h00000000, 1'b1, 17, 16};
    vecs[7] = '{1'b1, 32'h30,  32'h1234, 3'b001, 1'b1, 200, 32'hFFFF0000, 3'b001, 1'b1, 32'h00000000, 1'b1, 17, 16};
    vecs[8] = '{1'b1, 32'h34,  32'h0,    3'b010, 1'b0, 0,   32'hFFFFFFFF, 3'b010, 1'b0, 32'hFFFFFFFF, 1'b0, 2,  1};

    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0;
    bus.i_ls_req = 1'b0; bus.i_ls_addr = 32'h0; bus.i_ls_data = 32'h0;
    bus.i_ls_funct3 = 3'b000; bus.i_ls_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_req", bus.o_mem_req, 1'b0);
    check("rst_acks_err", {bus.o_if_ack, bus.o_ls_ack, bus.o_err}, 3'b000);
    check("rst_if_data", bus.o_if_data, 32'h0);
    check("rst_ls_data", bus.o_ls_data, 32'h0);
    check("rst_cmd", {bus.o_mem_addr, bus.o_mem_funct3, bus.o_mem_rw}, 36'h0);
    check("rst_mem_data", bus.o_mem_data, 32'h0);

    // Both requesters held continuously.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    arb_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(posedge clk); #1;
    mem_lat = 0; mem_rdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      e.is_ls = arb_ord[i]; e.data = 32'h77; e.err = 1'b0;
      sb_q.push_back(e);
    end
    bus.i_if_addr = 32'h40; bus.i_ls_addr = 32'h80; bus.i_ls_funct3 = 3'b010; bus.i_ls_rw = 1'b0;
    bus.i_if_req = 1'b1; bus.i_ls_req = 1'b1;
    n = 0; cyc = 0; prev = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.o_if_ack || bus.o_ls_ack) begin
        if (n > 0) check("arb_gap", cyc - prev, 3);
        prev = cyc;
        n++;
        if (n == 4) begin
          @(posedge clk); #1;
          bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
        end
      end
    end
    check("arb_acks", n, 4);
    check("arb_sb_drained", sb_q.size(), 0);

    do_reset();
    @(negedge clk);
    check("rst2_data", {bus.o_if_data, bus.o_ls_data}, 64'h0);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], 1'b0);

    // Reset in the middle of ISSUE abandons the transaction.
    @(posedge clk); #1;
    mem_lat = 200;
    bus.i_if_addr = 32'h300; bus.i_if_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_issue_req", bus.o_mem_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    bus.i_if_req = 1'b0;
    @(negedge clk);
    check("rst_req_dropped", bus.o_mem_req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_if_hold = 32'h0; exp_ls_hold = 32'h0;
    acks_before = ack_cnt; req_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_mem_req || bus.o_if_ack || bus.o_ls_ack) req_hi++;
    end
    check("rst_no_ack", ack_cnt - acks_before, 0);
    check("rst_no_activity", req_hi, 0);

    v = '{1'b0, 32'h44, 32'h0, 3'b000, 1'b0, 0, 32'h600DCAFE, 3'b010, 1'b0, 32'h600DCAFE, 1'b0, 2, 1};
    do_txn(v, 1'b0);

    // Request withdrawn right after grant still completes.
    v = '{1'b1, 32'h500, 32'h9, 3'b010, 1'b0, 2, 32'h0D0D0D0D, 3'b010, 1'b0, 32'h0D0D0D0D, 1'b0, 4, 3};
    do_txn(v, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
